// File: rtl/alu_div_pkg.sv
// Shared types and constants for the sequential divider.
// Holds the FSM state enum, default width and counter width helper.
package alu_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } div_state_t;

    localparam int DIV_WIDTH_DEFAULT = 8;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH_DEFAULT);

    // Counter width for an arbitrary operand width; never below 1 bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
// Ports: p_i partial remainder, q_msb_i bit shifted in, divisor_i;
//        next_p_o updated remainder, q_bit_o quotient bit produced.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] p_i,
    input  logic             q_msb_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] next_p_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // P < divisor on entry, so the shifted value is below 2*divisor and
    // the difference fits a signed WIDTH+1 result; its MSB is the borrow.
    assign shifted  = {p_i, q_msb_i};
    assign trial    = shifted - {1'b0, divisor_i};
    assign q_bit_o  = ~trial[WIDTH];
    assign next_p_o = q_bit_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Ports: clk, rst_n (async low), start, dividend, divisor in;
//        busy, done (1-cycle pulse), quotient, remainder, div_by_zero out.
module seq_divider
    import alu_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    div_state_t       state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] dvs_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;

    logic [WIDTH-1:0] p_d;
    logic             qbit_d;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .p_i       (p_q),
        .q_msb_i   (q_q[WIDTH-1]),
        .divisor_i (dvs_q),
        .next_p_o  (p_d),
        .q_bit_o   (qbit_d)
    );

    // q_q doubles as the captured dividend: it is loaded in both the
    // normal and divide-by-zero paths and never shifted for the latter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        dvs_q   <= divisor;
                        q_q     <= dividend;
                        p_q     <= '0;
                        cnt_q   <= CW'(WIDTH - 1);
                        dbz_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= (divisor == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    p_q   <= p_d;
                    q_q   <= {q_q[WIDTH-2:0], qbit_d};
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                    if (dvs_q == '0) begin
                        quot_q <= '1;
                        rem_q  <= q_q;
                        dbz_q  <= 1'b1;
                    end else begin
                        quot_q <= q_q;
                        rem_q  <= p_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: behavioural model plus
// hand-computed directed cases, random traffic and an operand sweep.
module tb_seq_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    bit cmp_en = 1'b0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            fails++;
            if (fails <= 30)
                $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Behavioural model: an accepted start yields a/b and a%b after a
    // fixed latency; nothing else is accepted while an op is pending.
    int unsigned  cyc = 0;
    int unsigned  m_done_at = 0;
    bit           m_busy = 1'b0;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    logic         e_busy = 1'b0;
    logic         e_done = 1'b0;
    logic         e_dbz = 1'b0;
    logic [W-1:0] e_q = '0;
    logic [W-1:0] e_r = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            e_busy = 1'b0;
            e_done = 1'b0;
            e_dbz  = 1'b0;
            e_q    = '0;
            e_r    = '0;
        end else begin
            cyc++;
            e_done = 1'b0;
            if (m_busy) begin
                if (cyc == m_done_at) begin
                    m_busy = 1'b0;
                    e_done = 1'b1;
                    if (m_b == 0) begin
                        e_q   = 8'hFF;
                        e_r   = m_a;
                        e_dbz = 1'b1;
                    end else begin
                        e_q = m_a / m_b;
                        e_r = m_a % m_b;
                    end
                end
            end else if (start) begin
                m_a       = dividend;
                m_b       = divisor;
                m_busy    = 1'b1;
                e_dbz     = 1'b0;
                m_done_at = cyc + ((divisor == 0) ? 1 : W + 1);
            end
            e_busy = m_busy;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("div_by_zero", div_by_zero, e_dbz);
            chk("quotient", quotient, e_q);
            chk("remainder", remainder, e_r);
        end
    end

    // Issue one op; lat counts negedges until done shows (edge latency
    // is lat-1), bcnt counts negedges with busy high before that.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int bcnt);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        lat  = 0;
        bcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start    = 1'b0;
            dividend = ~a;
            divisor  = b + 8'd1;
            lat++;
            if (done) break;
            if (busy) bcnt++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    int lat, bcnt, ndone;
    int dv[11] = '{1, 2, 3, 7, 15, 16, 127, 128, 200, 254, 255};

    initial begin
        #1 rst_n = 1'b0;
        cmp_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quot", quotient, 0);
        chk("rst_rem", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_op(8'd100, 8'd7, lat, bcnt);
        chk("100/7_latency", lat - 1, 9);
        chk("100/7_busy_cycles", bcnt, 9);
        chk("100/7_quot", quotient, 14);
        chk("100/7_rem", remainder, 2);
        chk("100/7_dbz", div_by_zero, 0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);

        do_op(8'd255, 8'd255, lat, bcnt);
        chk("255/255_quot", quotient, 1);
        chk("255/255_rem", remainder, 0);
        do_op(8'd5, 8'd200, lat, bcnt);
        chk("5/200_quot", quotient, 0);
        chk("5/200_rem", remainder, 5);
        do_op(8'd255, 8'd1, lat, bcnt);
        chk("255/1_quot", quotient, 255);
        chk("255/1_rem", remainder, 0);

        do_op(8'd42, 8'd0, lat, bcnt);
        chk("42/0_latency", lat - 1, 1);
        chk("42/0_quot", quotient, 8'hFF);
        chk("42/0_rem", remainder, 42);
        chk("42/0_dbz", div_by_zero, 1);
        do_op(8'd9, 8'd3, lat, bcnt);
        chk("9/3_quot", quotient, 3);
        chk("9/3_rem", remainder, 0);
        chk("9/3_dbz", div_by_zero, 0);

        @(negedge clk);
        start = 1'b1; dividend = 8'd200; divisor = 8'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; dividend = 8'd10; divisor = 8'd3;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                chk("200/9_quot", quotient, 22);
                chk("200/9_rem", remainder, 2);
            end
        end
        chk("ignored_start_dones", ndone, 1);

        @(negedge clk);
        start = 1'b1; dividend = 8'd100; divisor = 8'd7;
        ndone = 0;
        for (int i = 0; i < 46; i++) begin
            @(negedge clk);
            if (i == 39) start = 1'b0;
            if (done) ndone++;
        end
        chk("back_to_back_dones", ndone, 4);

        @(negedge clk);
        start = 1'b1; dividend = 8'd200; divisor = 8'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_quot", quotient, 0);
        chk("abort_rem", remainder, 0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 2) rst_n = 1'b1;
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        do_op(8'd50, 8'd6, lat, bcnt);
        chk("50/6_quot", quotient, 8);
        chk("50/6_rem", remainder, 2);

        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            start    = ($urandom_range(0, 3) == 0);
            dividend = W'($urandom);
            divisor  = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);

        for (int d = 0; d < 11; d++) begin
            for (int a = 0; a < 256; a++) begin
                do_op(W'(a), W'(dv[d]), lat, bcnt);
                chk("identity", quotient * dv[d] + remainder, a);
                chk("rem_lt_div", remainder < dv[d], 1);
            end
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
